sdram_rr_arbiter: RTL

//  Shares the single SDRAM controller port between NUM_PORTS mport_manager requesters.

---
 rtl/sdram_rr_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NUM_PORTS requesters.
// Latches the winner's command, holds SDRAM_as until done (or watchdog abort), then forces a release gap.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for SDRAM_ready and any req_as; grants the round-robin winner
// ST_BUSY    | SDRAM_as high with latched command; waiting for SDRAM_done or timeout
// ST_RELEASE | SDRAM_as low; waits for SDRAM_done to drop before re-arbitrating
module sdram_rr_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic [NUM_PORTS-1:0]    req_as,
    input  logic [NUM_PORTS-1:0]    req_rw,
    input  logic [NUM_PORTS*23-1:0] req_addr,
    input  logic [NUM_PORTS*16-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    req_done,
    output logic [NUM_PORTS-1:0]    req_err,
    output logic [15:0]             req_rdata,
    output logic                    grant_valid,
    output logic [3:0]              grant_idx,
    input  logic                    SDRAM_ready,
    output logic                    SDRAM_as,
    output logic                    SDRAM_rw,
    output logic [22:0]             SDRAM_addr,
    output logic [15:0]             SDRAM_data_write,
    input  logic [15:0]             SDRAM_data_read,
    input  logic                    SDRAM_done
);

    localparam int                CTR_W     = $clog2(TIMEOUT);
    localparam logic [3:0]        LAST_PORT = 4'(NUM_PORTS - 1);
    localparam logic [CTR_W-1:0]  CTR_LIMIT = CTR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [3:0]           gidx_q, gidx_d;
    logic                 as_q, as_d;
    logic                 gv_q, gv_d;
    logic                 rw_q, rw_d;
    logic [22:0]          addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic [NUM_PORTS-1:0] err_q, err_d;

    // Requester inputs padded to 16 slots so a 4-bit index selects them directly.
    logic [15:0] as_pad;
    logic [15:0] rw_pad;
    logic [22:0] addr_arr [16];
    logic [15:0] wdata_arr [16];

    always_comb begin
        as_pad = '0;
        rw_pad = '0;
        for (int i = 0; i < 16; i++) begin
            addr_arr[i]  = '0;
            wdata_arr[i] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            as_pad[i]    = req_as[i];
            rw_pad[i]    = req_rw[i];
            addr_arr[i]  = req_addr[23*i +: 23];
            wdata_arr[i] = req_wdata[16*i +: 16];
        end
    end

    // Scan from ptr downwards in priority so the port closest to ptr wins.
    logic       win_found;
    logic [3:0] win_idx;
    logic [4:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 5'(k);
            if (cand >= 5'(NUM_PORTS)) begin
                cand = cand - 5'(NUM_PORTS);
            end
            if (as_pad[cand[3:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[3:0];
            end
        end
    end

    logic [NUM_PORTS-1:0] grant_onehot;
    logic [3:0]           ptr_after;

    assign grant_onehot = NUM_PORTS'(1) << gidx_q;
    assign ptr_after    = (gidx_q == LAST_PORT) ? 4'd0 : gidx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ctr_d   = ctr_q;
        gidx_d  = gidx_q;
        as_d    = as_q;
        gv_d    = gv_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (SDRAM_ready && win_found) begin
                    rw_d    = rw_pad[win_idx];
                    addr_d  = addr_arr[win_idx];
                    wdata_d = wdata_arr[win_idx];
                    gidx_d  = win_idx;
                    as_d    = 1'b1;
                    gv_d    = 1'b1;
                    ctr_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion takes priority over a watchdog expiring on the same cycle.
                if (SDRAM_done) begin
                    rdata_d = SDRAM_data_read;
                    done_d  = grant_onehot;
                    as_d    = 1'b0;
                    gv_d    = 1'b0;
                    ptr_d   = ptr_after;
                    state_d = ST_RELEASE;
                end else if (ctr_q == CTR_LIMIT) begin
                    err_d   = grant_onehot;
                    as_d    = 1'b0;
                    gv_d    = 1'b0;
                    ptr_d   = ptr_after;
                    state_d = ST_RELEASE;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!SDRAM_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ctr_q   <= '0;
            gidx_q  <= '0;
            as_q    <= 1'b0;
            gv_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ctr_q   <= ctr_d;
            gidx_q  <= gidx_d;
            as_q    <= as_d;
            gv_q    <= gv_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_done         = done_q;
    assign req_err          = err_q;
    assign req_rdata        = rdata_q;
    assign grant_valid      = gv_q;
    assign grant_idx        = gidx_q;
    assign SDRAM_as         = as_q;
    assign SDRAM_rw         = rw_q;
    assign SDRAM_addr       = addr_q;
    assign SDRAM_data_write = wdata_q;

endmodule
